// File: rtl/vga_timing_if.sv
// Raster timing bundle: run enable into the generator, pixel strobe,
// counters, sync/blank decodes and delayed sync out of it.
interface vga_timing_if #(
   parameter int CNT_W = 10
);
   logic             en;
   logic             pixel_en;
   logic [CNT_W-1:0] pixel_x;
   logic [CNT_W-1:0] pixel_y;
   logic             hs;
   logic             vs;
   logic             hblank;
   logic             vblank;
   logic             blank;
   logic             last_column;
   logic             last_row;
   logic             line_start;
   logic             frame_start;
   logic             hs_d;
   logic             vs_d;
   logic             blank_d;

   modport master (
      input  en,
      output pixel_en, pixel_x, pixel_y, hs, vs, hblank, vblank, blank,
             last_column, last_row, line_start, frame_start, hs_d, vs_d, blank_d
   );

   modport slave (
      output en,
      input  pixel_en, pixel_x, pixel_y, hs, vs, hblank, vblank, blank,
             last_column, last_row, line_start, frame_start, hs_d, vs_d, blank_d
   );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: clock divider, x/y counters, sync and
// blank decode, plus a pixel-strobed delay pipe to match downstream fetch latency.
module vga_timing_gen #(
   parameter int H_ACTIVE   = 640,
   parameter int H_FP       = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BP       = 48,
   parameter int V_ACTIVE   = 480,
   parameter int V_FP       = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BP       = 29,
   parameter int CLK_DIV    = 2,
   parameter int HS_POL     = 0,
   parameter int VS_POL     = 0,
   parameter int SYNC_DELAY = 0,
   parameter int CNT_W      = 10
) (
   input logic               clk,
   input logic               rst,
   vga_timing_if.master      vif
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] X_LAST   = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] Y_LAST   = CNT_W'(V_TOTAL - 1);

   // Sync windows compared at 32 bits so an end bound equal to 2^CNT_W cannot wrap.
   localparam logic [31:0] HS_START = 32'(H_ACTIVE + H_FP);
   localparam logic [31:0] HS_END   = 32'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [31:0] VS_START = 32'(V_ACTIVE + V_FP);
   localparam logic [31:0] VS_END   = 32'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [31:0] H_ACT32  = 32'(H_ACTIVE);
   localparam logic [31:0] V_ACT32  = 32'(V_ACTIVE);
   localparam logic        HS_ON    = HS_POL[0];
   localparam logic        VS_ON    = VS_POL[0];

   logic [DIV_W-1:0] div_cnt;
   logic             pe_q;
   logic [CNT_W-1:0] x;
   logic [CNT_W-1:0] y;
   logic             pixel_en;
   logic             hs_raw;
   logic             vs_raw;
   logic             blank_raw;
   logic [31:0]      x32;
   logic [31:0]      y32;

   // pe_q is held while frozen so resuming picks up the exact same phase.
   always_ff @(posedge clk) begin
      if (!rst) begin
         div_cnt <= '0;
         pe_q    <= 1'b0;
         x       <= '0;
         y       <= '0;
      end else if (vif.en) begin
         div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
         pe_q    <= (div_cnt == DIV_LAST);
         if (pe_q) begin
            if (x == X_LAST) begin
               x <= '0;
               y <= (y == Y_LAST) ? '0 : y + CNT_W'(1);
            end else begin
               x <= x + CNT_W'(1);
            end
         end
      end
   end

   assign pixel_en  = pe_q & vif.en;
   assign x32       = 32'(x);
   assign y32       = 32'(y);
   assign hs_raw    = (x32 >= HS_START && x32 < HS_END) ? HS_ON : ~HS_ON;
   assign vs_raw    = (y32 >= VS_START && y32 < VS_END) ? VS_ON : ~VS_ON;
   assign blank_raw = (x32 >= H_ACT32) | (y32 >= V_ACT32);

   assign vif.pixel_en    = pixel_en;
   assign vif.pixel_x     = x;
   assign vif.pixel_y     = y;
   assign vif.hs          = hs_raw;
   assign vif.vs          = vs_raw;
   assign vif.hblank      = (x32 >= H_ACT32);
   assign vif.vblank      = (y32 >= V_ACT32);
   assign vif.blank       = blank_raw;
   assign vif.last_column = (x32 == H_ACT32 - 32'd1);
   assign vif.last_row    = (y32 == V_ACT32 - 32'd1);
   assign vif.line_start  = pixel_en & (x == X_LAST);
   assign vif.frame_start = pixel_en & (x == X_LAST) & (y == Y_LAST);

   generate
      if (SYNC_DELAY == 0) begin : g_no_delay
         assign vif.hs_d    = hs_raw;
         assign vif.vs_d    = vs_raw;
         assign vif.blank_d = blank_raw;
      end else begin : g_delay
         // Each stage holds {hs, vs, blank}; stage 0 is the newest pixel.
         logic [2:0] pipe [SYNC_DELAY];

         always_ff @(posedge clk) begin
            if (!rst) begin
               for (int i = 0; i < SYNC_DELAY; i++) pipe[i] <= {~HS_ON, ~VS_ON, 1'b1};
            end else if (pixel_en) begin
               pipe[0] <= {hs_raw, vs_raw, blank_raw};
               for (int i = 1; i < SYNC_DELAY; i++) pipe[i] <= pipe[i-1];
            end
         end

         assign vif.hs_d    = pipe[SYNC_DELAY-1][2];
         assign vif.vs_d    = pipe[SYNC_DELAY-1][1];
         assign vif.blank_d = pipe[SYNC_DELAY-1][0];
      end
   endgenerate

endmodule
